// File: rtl/debouncing_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package debouncing_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_MS = 2;

    // Cycles in a debounce window: freq * ms / 1000 (64-bit intermediate avoids overflow).
    function automatic int stable_cycles(input longint freq, input longint ms);
        return int'((freq * ms) / 64'd1000);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Both taps are exported so they can be probed by a logic analyser.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q1,
    output logic q2
);

    // Shift the raw level through two flops; q2 is safe to use downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

endmodule

// File: rtl/debouncing.sv
// Push-button debouncer: 2-flop synchroniser followed by a stability counter.
// dbsig only takes a new level after the synchronised input has held it for
// STABLE_CYCLES consecutive edges; any return to the current level restarts.
// Optional macro DEBOUNCING_PULSE_EN adds a one-cycle press_pulse output.
module debouncing
    import debouncing_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = DEFAULT_CLK_FREQ_HZ,
    parameter int STABLE_CYCLES = stable_cycles(CLK_FREQ_HZ, DEFAULT_DEBOUNCE_MS),
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic LED,
    output logic dbsig,
    output logic button_out1,
    output logic button_out2
`ifdef DEBOUNCING_PULSE_EN
    ,
    output logic press_pulse
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q1  (button_out1),
        .q2  (button_out2)
    );

    // Count consecutive edges where the synchronised level disagrees with dbsig;
    // accept the new level when the count completes, never letting cnt wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            dbsig <= 1'b0;
        end else if (button_out2 == dbsig) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            dbsig <= button_out2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign LED = dbsig;

`ifdef DEBOUNCING_PULSE_EN
    logic dbsig_d;

    // Delay dbsig one edge and flag its rising transition for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbsig_d     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            dbsig_d     <= dbsig;
            press_pulse <= dbsig & ~dbsig_d;
        end
    end
`endif

endmodule

// File: tb/tb_debouncing.sv
// Scoreboard bench for debouncing: two DUTs (STABLE_CYCLES=8 and =1) share stimulus.
// A window-based reference model pushes expected outputs per edge; a monitor pops
// and compares on the falling edge.
module tb_debouncing;

    localparam int S = 8;
    localparam int SV [2] = '{S, 1};

    logic clk = 1'b0;
    logic rst, btn;
    logic led8, db8, b8o1, b8o2;
    logic led1, db1, b1o1, b1o2;
`ifdef DEBOUNCING_PULSE_EN
    logic pl8, pl1;
`endif

    always #10 clk = ~clk;

    debouncing #(.STABLE_CYCLES(S)) dut8 (
        .clk(clk), .rst(rst), .btn(btn), .LED(led8), .dbsig(db8),
        .button_out1(b8o1), .button_out2(b8o2)
`ifdef DEBOUNCING_PULSE_EN
        , .press_pulse(pl8)
`endif
    );

    debouncing #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .btn(btn), .LED(led1), .dbsig(db1),
        .button_out1(b1o1), .button_out2(b1o2)
`ifdef DEBOUNCING_PULSE_EN
        , .press_pulse(pl1)
`endif
    );

    typedef struct {
        logic       bo1;
        logic       bo2;
        logic [1:0] db;
        logic [1:0] pl;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: bo2 is btn delayed two edges; dbsig flips at an edge when the
    // last S pre-edge bo2 values since reset all differ from the current dbsig.
    initial begin
        logic       m_bo1, m_bo2;
        logic [1:0] m_db, m_pl, m_rose;
        logic       hist[$];
        exp_t       e;
        bit         all_diff;
        m_bo1 = 0; m_bo2 = 0; m_db = 0; m_pl = 0; m_rose = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_bo1 = 0; m_bo2 = 0; m_db = 0; m_pl = 0; m_rose = 0;
                hist.delete();
            end else begin
                hist.push_back(m_bo2);
                if (hist.size() > 16) void'(hist.pop_front());
                for (int k = 0; k < 2; k++) begin
                    m_pl[k]   = m_rose[k];
                    m_rose[k] = 1'b0;
                    if (hist.size() >= SV[k]) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < SV[k]; j++)
                            if (hist[hist.size() - 1 - j] == m_db[k]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_db[k]   = ~m_db[k];
                            m_rose[k] = m_db[k];
                        end
                    end
                end
                m_bo2 = m_bo1;
                m_bo1 = btn;
            end
            e.bo1 = m_bo1; e.bo2 = m_bo2; e.db = m_db; e.pl = m_pl;
            sb.push_back(e);
        end
    end

    // Monitor: pop one expectation per cycle; an asserted reset forces zeros at once.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (rst) begin
                    e.bo1 = 0; e.bo2 = 0; e.db = 0; e.pl = 0;
                end
                check("s8_bo1", b8o1, e.bo1);
                check("s8_bo2", b8o2, e.bo2);
                check("s8_dbsig", db8, e.db[0]);
                check("s8_led", led8, e.db[0]);
                check("s1_bo1", b1o1, e.bo1);
                check("s1_bo2", b1o2, e.bo2);
                check("s1_dbsig", db1, e.db[1]);
                check("s1_led", led1, e.db[1]);
`ifdef DEBOUNCING_PULSE_EN
                check("s8_pulse", pl8, e.pl[0]);
                check("s1_pulse", pl1, e.pl[1]);
`endif
            end
        end
    end

    // Count edges (first edge = the one sampling the new btn) until dbsig reaches target.
    task automatic measure(input string name, input logic target, input int exp8, input int exp1);
        int  n  = 0;
        int  n8 = -1;
        int  n1 = -1;
        while (n < 60 && (n8 < 0 || n1 < 0)) begin
            @(posedge clk); #8;
            n++;
            if (n8 < 0 && db8 === target) n8 = n;
            if (n1 < 0 && db1 === target) n1 = n;
        end
        check_int({name, "_lat_s8"}, n8, exp8);
        check_int({name, "_lat_s1"}, n1, exp1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #3;
        end
    endtask

    initial begin
        int hold;
        int cyc;
        rst = 1'b1;
        btn = 1'b1;

        // Reset held with button pressed; dbsig rises 10 edges after release.
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        measure("rst_release", 1'b1, S + 2, 3);

        // Clean press from a settled released state.
        step(1); btn = 1'b0;
        step(20);
        btn = 1'b1;
        measure("clean_press", 1'b1, S + 2, 3);

        // Bounce every 3 cycles, then a final stable press.
        step(10); btn = 1'b0;
        step(20);
        for (int i = 0; i < 42; i++) begin
            btn = ((i / 3) % 2 == 0);
            step(1);
        end
        btn = 1'b1;
        measure("bounce", 1'b1, S + 2, 3);

        // Release interrupted by a 5-cycle glitch high restarts the count.
        step(10);
        btn = 1'b0; step(4);
        btn = 1'b1; step(5);
        btn = 1'b0;
        measure("release", 1'b0, S + 2, 3);

        // Reset while the count is at 5; requalify from scratch afterwards.
        step(20);
        btn = 1'b1;
        step(7);
        rst = 1'b1;
        #1 check("rst_async_dbsig", db8, 1'b0);
        check("rst_async_bo2", b8o2, 1'b0);
        @(posedge clk); #3;
        @(posedge clk); #3;
        rst = 1'b0;
        measure("rst_mid", 1'b1, S + 2, 3);

        // Random bursts of button activity with occasional one-cycle resets.
        cyc = 0;
        while (cyc < 2500) begin
            hold = $urandom_range(1, 12);
            btn  = 1'($urandom_range(0, 1));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #3;
                rst = ($urandom_range(0, 299) == 0);
                cyc++;
            end
        end
        rst = 1'b0;
        step(3);
        @(negedge clk); #1;
        check_int("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
